// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: turns make/break byte streams into one press event per letter
// key, filters typematic repeats and queues events in a small first-word fall-through FIFO.
module ps2_key_event_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  scan_code,
    input  logic        scan_valid,
    input  logic        key_ready,
    output logic [4:0]  key_letter,
    output logic        key_valid,
    output logic [15:0] held_mask,
    output logic        fifo_overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BAT   = 8'hAA;

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } state_t;

    state_t            state;
    logic [TO_W-1:0]   timeout_cnt;
    logic [4:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              code_mapped;
    logic [4:0]        code_letter;
    logic              push_req;
    logic              do_push;
    logic              pop;
    logic              full;
    logic [CNT_W-1:0]  next_count;
    logic [PTR_W-1:0]  rd_next;

    always_comb begin
        code_mapped = 1'b1;
        code_letter = 5'd0;
        case (scan_code)
            8'h1C: code_letter = 5'd0;
            8'h32: code_letter = 5'd1;
            8'h21: code_letter = 5'd2;
            8'h23: code_letter = 5'd3;
            8'h24: code_letter = 5'd4;
            8'h2B: code_letter = 5'd5;
            8'h34: code_letter = 5'd6;
            8'h33: code_letter = 5'd7;
            8'h3B: code_letter = 5'd8;
            8'h4B: code_letter = 5'd9;
            8'h31: code_letter = 5'd10;
            8'h44: code_letter = 5'd11;
            8'h4D: code_letter = 5'd12;
            8'h2D: code_letter = 5'd13;
            8'h1B: code_letter = 5'd14;
            8'h35: code_letter = 5'd15;
            default: code_mapped = 1'b0;
        endcase
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still succeeds.
    always_comb begin
        push_req = scan_valid && (state == IDLE) && code_mapped
                   && !held_mask[code_letter[3:0]];
        pop      = key_valid && key_ready;
        full     = (count == CNT_W'(FIFO_DEPTH));
        do_push  = push_req && (!full || pop);
        rd_next  = rd_ptr + PTR_W'(1);
        case ({do_push, pop})
            2'b10:   next_count = count + CNT_W'(1);
            2'b01:   next_count = count - CNT_W'(1);
            default: next_count = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timeout_cnt   <= '0;
            held_mask     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            key_valid     <= 1'b0;
            key_letter    <= 5'd0;
            fifo_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 5'd0;
            end
        end else begin
            if (scan_valid) begin
                timeout_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (scan_code == CODE_BREAK) begin
                            state <= BREAK;
                        end else if (scan_code == CODE_EXT) begin
                            state <= EXT;
                        end else if (scan_code == CODE_BAT) begin
                            held_mask <= '0;
                        end else if (push_req) begin
                            held_mask[code_letter[3:0]] <= 1'b1;
                        end
                    end
                    BREAK: begin
                        if (code_mapped) begin
                            held_mask[code_letter[3:0]] <= 1'b0;
                        end
                        state <= IDLE;
                    end
                    EXT: begin
                        state <= (scan_code == CODE_BREAK) ? EXT_BREAK : IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE) begin
                // A lost follow-up byte must not leave the sequencer stuck in a prefix state.
                if (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state       <= IDLE;
                    timeout_cnt <= '0;
                end else begin
                    timeout_cnt <= timeout_cnt + TO_W'(1);
                end
            end

            if (do_push) begin
                mem[wr_ptr] <= code_letter;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push_req && full && !pop) begin
                fifo_overflow <= 1'b1;
            end
            count     <= next_count;
            key_valid <= (next_count != '0);

            // key_letter is a registered copy of the next head entry.
            if (do_push && ((count == '0) || (pop && count == CNT_W'(1)))) begin
                key_letter <= code_letter;
            end else if (pop && count > CNT_W'(1)) begin
                key_letter <= mem[rd_next];
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed-vector bench for ps2_key_event_ctrl with a shortened prefix timeout.
module tb_ps2_key_event_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  scan_code = 8'h00;
    logic        scan_valid = 1'b0;
    logic        key_ready = 1'b0;
    logic [4:0]  key_letter;
    logic        key_valid;
    logic [15:0] held_mask;
    logic        fifo_overflow;

    int n_vectors = 0;
    int n_miscompares = 0;

    ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .scan_code    (scan_code),
        .scan_valid   (scan_valid),
        .key_ready    (key_ready),
        .key_letter   (key_letter),
        .key_valid    (key_valid),
        .held_mask    (held_mask),
        .fifo_overflow(fifo_overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Inputs change on the falling edge; outputs are observed on the following falling edge.
    task automatic applyStimulus(input logic [7:0] code);
        scan_code  = code;
        scan_valid = 1'b1;
        tick();
        scan_valid = 1'b0;
    endtask

    task automatic popExpect(input string tag, input logic [4:0] exp);
        checkOutput({tag, "_valid"}, {31'd0, key_valid}, 32'd1);
        checkOutput({tag, "_letter"}, {27'd0, key_letter}, {27'd0, exp});
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        checkOutput("rst_valid", {31'd0, key_valid}, 32'd0);
        checkOutput("rst_letter", {27'd0, key_letter}, 32'd0);
        checkOutput("rst_held", {16'd0, held_mask}, 32'd0);
        checkOutput("rst_ovf", {31'd0, fifo_overflow}, 32'd0);

        // Press and release with the consumer always ready.
        key_ready = 1'b1;
        applyStimulus(8'h1C);
        checkOutput("pr_valid", {31'd0, key_valid}, 32'd1);
        checkOutput("pr_letter", {27'd0, key_letter}, 32'd0);
        checkOutput("pr_held", {16'd0, held_mask}, 32'h0001);
        applyStimulus(8'hF0);
        checkOutput("pr_popped", {31'd0, key_valid}, 32'd0);
        checkOutput("pr_held_f0", {16'd0, held_mask}, 32'h0001);
        applyStimulus(8'h1C);
        checkOutput("pr_released", {16'd0, held_mask}, 32'h0000);
        checkOutput("pr_no_push", {31'd0, key_valid}, 32'd0);
        key_ready = 1'b0;

        // Typematic repeats collapse into one event.
        applyStimulus(8'h1C);
        applyStimulus(8'h1C);
        applyStimulus(8'h1C);
        checkOutput("tm_held", {16'd0, held_mask}, 32'h0001);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        checkOutput("tm_rel", {16'd0, held_mask}, 32'h0000);
        popExpect("tm_ev", 5'd0);
        checkOutput("tm_one_event", {31'd0, key_valid}, 32'd0);
        applyStimulus(8'h1C);
        popExpect("tm_ev2", 5'd0);
        checkOutput("tm_empty", {31'd0, key_valid}, 32'd0);

        // Extended sequences never push or touch held_mask.
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        checkOutput("ext_brk_valid", {31'd0, key_valid}, 32'd0);
        checkOutput("ext_brk_held", {16'd0, held_mask}, 32'h0001);
        applyStimulus(8'hE0);
        applyStimulus(8'h1C);
        checkOutput("ext_valid", {31'd0, key_valid}, 32'd0);
        applyStimulus(8'h32);
        checkOutput("ext_idle_held", {16'd0, held_mask}, 32'h0003);
        popExpect("ext_idle_ev", 5'd1);
        applyStimulus(8'hF0);
        applyStimulus(8'h1C);
        applyStimulus(8'hF0);
        applyStimulus(8'h32);
        checkOutput("ext_clean", {16'd0, held_mask}, 32'h0000);

        // Five presses into a four-deep queue with no consumer.
        applyStimulus(8'h1C);
        applyStimulus(8'h32);
        applyStimulus(8'h21);
        applyStimulus(8'h23);
        checkOutput("of_not_yet", {31'd0, fifo_overflow}, 32'd0);
        applyStimulus(8'h24);
        checkOutput("of_set", {31'd0, fifo_overflow}, 32'd1);
        checkOutput("of_held", {16'd0, held_mask}, 32'h001F);
        popExpect("of_d0", 5'd0);
        popExpect("of_d1", 5'd1);
        popExpect("of_d2", 5'd2);
        popExpect("of_d3", 5'd3);
        checkOutput("of_drained", {31'd0, key_valid}, 32'd0);
        checkOutput("of_sticky", {31'd0, fifo_overflow}, 32'd1);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        checkOutput("empty_ready", {31'd0, key_valid}, 32'd0);
        applyStimulus(8'hAA);
        checkOutput("bat_clear", {16'd0, held_mask}, 32'h0000);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst2_ovf", {31'd0, fifo_overflow}, 32'd0);
        checkOutput("rst2_letter", {27'd0, key_letter}, 32'd0);

        // Full queue: fifth press lands in the same cycle as a pop.
        applyStimulus(8'h1C);
        applyStimulus(8'h32);
        applyStimulus(8'h21);
        applyStimulus(8'h23);
        scan_code  = 8'h24;
        scan_valid = 1'b1;
        key_ready  = 1'b1;
        tick();
        scan_valid = 1'b0;
        key_ready  = 1'b0;
        checkOutput("fp_no_ovf", {31'd0, fifo_overflow}, 32'd0);
        popExpect("fp_d1", 5'd1);
        popExpect("fp_d2", 5'd2);
        popExpect("fp_d3", 5'd3);
        popExpect("fp_d4", 5'd4);
        checkOutput("fp_drained", {31'd0, key_valid}, 32'd0);

        // Prefix timeout: one cycle short is still a break, the full count returns to IDLE.
        applyStimulus(8'hAA);
        applyStimulus(8'h1C);
        popExpect("to_setup", 5'd0);
        applyStimulus(8'hF0);
        repeat (TMO - 1) tick();
        applyStimulus(8'h1C);
        checkOutput("to_short_held", {16'd0, held_mask}, 32'h0000);
        checkOutput("to_short_valid", {31'd0, key_valid}, 32'd0);
        applyStimulus(8'hF0);
        repeat (TMO) tick();
        applyStimulus(8'h1C);
        checkOutput("to_held", {16'd0, held_mask}, 32'h0001);
        checkOutput("to_valid", {31'd0, key_valid}, 32'd1);
        checkOutput("to_letter", {27'd0, key_letter}, 32'd0);

        // Reset in BREAK with a full queue and sticky overflow, colliding with a byte and pop.
        applyStimulus(8'h32);
        applyStimulus(8'h21);
        applyStimulus(8'h23);
        applyStimulus(8'h24);
        checkOutput("mr_ovf", {31'd0, fifo_overflow}, 32'd1);
        applyStimulus(8'hF0);
        rst        = 1'b1;
        scan_code  = 8'h1C;
        scan_valid = 1'b1;
        key_ready  = 1'b1;
        tick();
        rst        = 1'b0;
        scan_valid = 1'b0;
        key_ready  = 1'b0;
        checkOutput("mr_valid", {31'd0, key_valid}, 32'd0);
        checkOutput("mr_held", {16'd0, held_mask}, 32'h0000);
        checkOutput("mr_ovf_clr", {31'd0, fifo_overflow}, 32'd0);
        applyStimulus(8'h1C);
        checkOutput("mr_idle_push", {31'd0, key_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
